// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
//   Groups the three buses of the load/store unit: the execute-stage request,
//   the data-memory port and the write-back beat, plus the stall flag.
//
//   Parameters: DATA_W (32/64), ADDR_W, RD_W; NB = DATA_W/8 byte lanes.
//
//   Signals:
//     req_valid/req_ready    execute -> LSU handshake
//     req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd
//     mem_req_valid/mem_req_ready, mem_addr, mem_we, mem_be, mem_wdata
//     mem_rsp_valid, mem_rdata
//     wb_valid, wb_rd, wb_data
//     stall                  LSU busy (state != IDLE)
//
//   Modports:
//     slave  - the LSU itself
//     master - the surrounding pipeline and memory (or a testbench)
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              stall;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output wb_valid, wb_rd, wb_data,
    output stall
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  wb_valid, wb_rd, wb_data,
    input  stall
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Load/store unit for the memory/write-back stage of the pipelined MIPS
//   core. Takes one access per handshake from execute, issues it on a
//   valid/ready data-memory port with byte enables, and returns load data
//   aligned and sign/zero-extended as a registered one-cycle write-back beat.
//   Tolerates variable-latency memory; stall is high whenever busy.
//
//   Ports:
//     CLK           clock, all state updates on posedge
//     reset         synchronous, active-high
//     misalign_err  (only with LSU_MISALIGN_TRAP_EN) one-cycle trap pulse
//     bus           lsu_mem_stage_if.slave (request, memory, write-back, stall)
//
//   Byte order is big-endian: byte offset k of an NB-byte word sits in lane
//   NB-1-k. Size 2'b11 means dword and is treated as word when DATA_W=32.
//
//   Configuration macro LSU_MISALIGN_TRAP_EN:
//     undefined - misaligned addresses are silently aligned to the access size
//     defined   - a misaligned access is dropped in ISSUE, misalign_err pulses
//                 for one cycle and the LSU returns to IDLE without write-back
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int DATA_W = 32,  // 32 or 64
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic CLK,
  input  logic reset,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic misalign_err,
`endif
  lsu_mem_stage_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nxt;

  // Request holding registers, loaded on the IDLE handshake.
  logic              h_we;
  logic              h_unsigned;
  logic [1:0]        h_size;     // already folded: dword -> word on 32-bit
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [RD_W-1:0]   h_rd;

  logic              req_fire;
  logic [1:0]        req_size_eff;

  // Lane decode derived from the held request.
  int                n_bytes;     // access size in bytes
  logic [OFF_W-1:0]  lane_off;    // size-aligned byte offset within the word
  int                lane_shift;  // byte distance of the access from lane 0
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] ext_mask;    // ones above the accessed field
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              misaligned;
`endif

  assign req_fire     = bus.req_valid && (state == S_IDLE);
  assign req_size_eff = (DATA_W == 32 && bus.req_size == 2'b11) ? 2'b10 : bus.req_size;

  // ------------------------------------------------------------------------
  // Lane / byte-enable decode and data steering
  // ------------------------------------------------------------------------
  always_comb begin
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sign_pos;
    logic [DATA_W-1:0] wfield;

    n_bytes    = 32'd1 << h_size;
    lane_off   = h_addr[OFF_W-1:0] & ~OFF_W'(n_bytes - 1);
    lane_shift = NB - n_bytes - int'(lane_off);
    be         = NB'((1 << n_bytes) - 1) << lane_shift;
    ext_mask   = {DATA_W{1'b1}} << (8 * n_bytes);

    // Store: right-justified field replicated across every size-aligned slot.
    wfield     = h_wdata & ~ext_mask;
    store_data = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i & (n_bytes - 1)) == 0)
        store_data = store_data | (wfield << (8 * i));
    end

    // Load: bring the addressed lanes down to bit 0, then extend.
    shifted   = bus.mem_rdata >> (8 * lane_shift);
    sign_pos  = DATA_W'(1) << (8 * n_bytes - 1);
    load_data = (shifted & ~ext_mask) |
                ((!h_unsigned && |(shifted & sign_pos)) ? ext_mask : '0);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |(h_addr[OFF_W-1:0] & OFF_W'(n_bytes - 1));
`endif

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_nxt = S_ISSUE;
      S_ISSUE: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned)             state_nxt = S_IDLE;
        else
`endif
        if (bus.mem_req_ready)      state_nxt = h_we ? S_IDLE : S_WAIT;
      end
      S_WAIT:  if (bus.mem_rsp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.stall         = 1'b1;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_we        = 1'b0;
    bus.mem_be        = '0;
    bus.mem_wdata     = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = 1'b0;
      end
      S_ISSUE: begin
        // Driven purely from holding registers, so stable while ready is low.
        bus.mem_req_valid = 1'b1;
        bus.mem_addr      = {h_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        bus.mem_we        = h_we;
        bus.mem_be        = be;
        bus.mem_wdata     = h_we ? store_data : '0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned) begin
          bus.mem_req_valid = 1'b0;
          misalign_err      = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------------
  // Request holding registers
  // ------------------------------------------------------------------------
  // NOTE: these data registers are reset as well; it costs little here and
  // keeps the lane decode free of X after reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      h_we       <= 1'b0;
      h_unsigned <= 1'b0;
      h_size     <= 2'b00;
      h_addr     <= '0;
      h_wdata    <= '0;
      h_rd       <= '0;
    end else if (req_fire) begin
      h_we       <= bus.req_we;
      h_unsigned <= bus.req_unsigned;
      h_size     <= req_size_eff;
      h_addr     <= bus.req_addr;
      h_wdata    <= bus.req_wdata;
      h_rd       <= bus.req_rd;
    end
  end

  // ------------------------------------------------------------------------
  // Write-back beat: responses outside WAIT are ignored.
  // ------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
    end else begin
      bus.wb_valid <= (state == S_WAIT) && bus.mem_rsp_valid;
      if ((state == S_WAIT) && bus.mem_rsp_valid) begin
        bus.wb_rd   <= h_rd;
        bus.wb_data <= load_data;
      end
    end
  end

endmodule
